// File: rtl/char_stream_pkg.sv
// Shared types and constants for the character stream transmitter:
// FSM states, gap-mode encodings and the pseudo-random gap generator.
package char_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GAP_NONE     = 2'd0,
    GAP_FIXED    = 2'd1,
    GAP_RANDOM   = 2'd2,
    GAP_NONE_ALT = 2'd3
  } gap_mode_e;

  localparam int                LFSR_W    = 8;
  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam int                GAP_MOD   = 5;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [2:0] lfsr_gap(input logic [LFSR_W-1:0] v);
    return 3'(v % GAP_MOD);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Character FIFO: register storage with registered count and FULL/EMPTY flags.
// A write is taken only when not full; pops are issued only when non-empty.
module char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [6:0]             wr_data,
  input  logic                   pop,
  output logic [6:0]             head,
  output logic                   wr_accept,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;

  // A full FIFO drops the write even if a pop happens on the same edge.
  assign wr_accept = wr_en && !full;
  assign head      = mem[rd_ptr];

  always_comb begin
    // NOTE: assign a default first so every path drives count_next and no latch is inferred.
    count_next = count;
    case ({wr_accept, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // NOTE: storage is not reset; the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/char_stream_tx.sv
// Character stream transmitter: buffers 7-bit characters and emits one per
// RDY strobe, separated by a gap that is none, fixed, or LFSR pseudo-random.
module char_stream_tx
  import char_stream_pkg::*;
#(
  parameter int                DEPTH = 8,
  parameter logic [LFSR_W-1:0] SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic [1:0]  gap_mode,
  input  logic [2:0]  gap_len,
  output logic        rdy,
  output logic [6:0]  dout,
  output logic        full,
  output logic        empty,
  output logic        ovf,
  output logic [15:0] sent_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state;
  state_e            gap_state;
  logic [LFSR_W-1:0] lfsr;
  logic [2:0]        gap_cnt;
  logic [2:0]        gap_k;
  logic [CW-1:0]     count;
  logic [6:0]        head;
  logic              wr_accept;
  logic              pop;
  logic              more_after_pop;
  logic              unused_bit7;

  // Bit 7 of the incoming character is discarded by design.
  assign unused_bit7 = wr_data[7];

  char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data[6:0]),
    .pop       (pop),
    .head      (head),
    .wr_accept (wr_accept),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign pop            = (state == ST_SEND) && en && !empty;
  assign more_after_pop = wr_accept || (count > CW'(1));

  // Gap length is sampled only here, at the moment a new character is scheduled.
  always_comb begin
    gap_k = '0;
    case (gap_mode_e'(gap_mode))
      GAP_FIXED:  gap_k = gap_len;
      GAP_RANDOM: gap_k = lfsr_gap(lfsr);
      default:    gap_k = '0;
    endcase
  end

  assign gap_state = (gap_k == '0) ? ST_SEND : ST_GAP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lfsr     <= SEED;
      gap_cnt  <= '0;
      rdy      <= 1'b0;
      dout     <= '0;
      ovf      <= 1'b0;
      sent_cnt <= '0;
    end else begin
      rdy <= 1'b0;
      if (wr_en && full) ovf <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (en && !empty) begin
            lfsr    <= lfsr_step(lfsr);
            state   <= gap_state;
            gap_cnt <= gap_k;
          end
        end

        // Counter freezes while disabled; the last enabled count arms SEND.
        ST_GAP: begin
          if (en) begin
            if (gap_cnt == 3'd1) begin
              state   <= ST_SEND;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt - 3'd1;
            end
          end
        end

        ST_SEND: begin
          if (pop) begin
            rdy      <= 1'b1;
            dout     <= head;
            sent_cnt <= sent_cnt + 16'd1;
            if (more_after_pop) begin
              lfsr    <= lfsr_step(lfsr);
              state   <= gap_state;
              gap_cnt <= gap_k;
            end else begin
              state <= ST_IDLE;
            end
          end else if (empty) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_tx.sv
// Self-checking bench for char_stream_tx: a queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed timing.
module tb_char_stream_tx;
  localparam int         DEPTH = 8;
  localparam logic [7:0] SEED  = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [1:0]  gap_mode;
  logic [2:0]  gap_len;
  logic        rdy;
  logic [6:0]  dout;
  logic        full;
  logic        empty;
  logic        ovf;
  logic [15:0] sent_cnt;

  char_stream_tx #(.DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .gap_mode (gap_mode),
    .gap_len  (gap_len),
    .rdy      (rdy),
    .dout     (dout),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .sent_cnt (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each scheduled character needs (gap + 1) enabled edges
  // before it is strobed out; the budget only counts down on enabled edges.
  logic [6:0]  mq[$];
  bit          m_busy;
  int          m_rem;
  logic [7:0]  m_lfsr;
  logic        m_rdy;
  logic [6:0]  m_dout;
  logic        m_ovf;
  logic [15:0] m_sent;
  int          m_sz;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int take_gap();
    int k;
    k = 0;
    if (gap_mode == 2'd1)      k = int'(gap_len);
    else if (gap_mode == 2'd2) k = int'(m_lfsr) % 5;
    m_lfsr = lfsr_next(m_lfsr);
    return k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 1'b0;
      m_rem  = 0;
      m_lfsr = SEED;
      m_rdy  = 1'b0;
      m_dout = '0;
      m_ovf  = 1'b0;
      m_sent = '0;
    end else begin
      m_sz  = mq.size();
      m_rdy = 1'b0;
      if (wr_en && m_sz == DEPTH) m_ovf = 1'b1;
      if (m_busy && en) begin
        m_rem--;
        if (m_rem == 0) begin
          m_rdy  = 1'b1;
          m_dout = mq.pop_front();
          m_sent = m_sent + 16'd1;
        end
      end
      if (wr_en && m_sz < DEPTH) mq.push_back(wr_data[6:0]);
      if (m_busy && m_rdy) begin
        if (mq.size() > 0) m_rem = take_gap() + 1;
        else               m_busy = 1'b0;
      end else if (!m_busy && en && m_sz > 0) begin
        m_busy = 1'b1;
        m_rem  = take_gap() + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("rdy",      32'(rdy),      32'(m_rdy));
      check("dout",     32'(dout),     32'(m_dout));
      check("full",     32'(full),     32'(mq.size() == DEPTH));
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("ovf",      32'(ovf),      32'(m_ovf));
      check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
    end
  end

  // Strobe monitor: cycle stamps, values and RDY=0 run lengths between strobes.
  int         cyc = 0;
  int         st_cyc[$];
  logic [6:0] st_val[$];
  int         gaps[$];
  bit         have_prev;
  int         gap_run;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rdy === 1'b1) begin
        st_cyc.push_back(cyc);
        st_val.push_back(dout);
        if (have_prev) gaps.push_back(gap_run);
        have_prev = 1'b1;
        gap_run   = 0;
      end else begin
        gap_run++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    st_cyc.delete();
    st_val.delete();
    gaps.delete();
    have_prev = 1'b0;
    gap_run   = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},   32'(rdy),      32'(0));
    check({tag, "_dout"},  32'(dout),     32'(0));
    check({tag, "_empty"}, 32'(empty),    32'(1));
    check({tag, "_full"},  32'(full),     32'(0));
    check({tag, "_ovf"},   32'(ovf),      32'(0));
    check({tag, "_sent"},  32'(sent_cnt), 32'(0));
  endtask

  task automatic do_reset();
    tick();
    rst_n    = 1'b0;
    en       = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    gap_mode = 2'd0;
    gap_len  = 3'd0;
    #1;
    check_reset_vals("reset");
    tick();
    clear_mon();
    rst_n = 1'b1;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int t = 0;
    while (st_val.size() < n && t < budget) begin
      tick();
      t++;
    end
    check(name, 32'(st_val.size()), 32'(n));
  endtask

  task automatic write_char(input logic [7:0] c);
    wr_en   = 1'b1;
    wr_data = c;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int bad;
    int n_wr;
    int guard;
    int wr_pct;

    rst_n    = 1'b0;
    en       = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    gap_mode = 2'd0;
    gap_len  = 3'd0;

    // Mode 0: 'A','B','C' on consecutive edges -> three back-to-back strobes.
    do_reset();
    en = 1'b1;
    c0 = cyc;
    wr_en = 1'b1; wr_data = "A"; tick();
    wr_data = "B"; tick();
    wr_data = "C"; tick();
    wr_en = 1'b0;
    wait_strobes(3, 50, "abc_count");
    tick(); tick();
    if (st_val.size() >= 3) begin
      check("abc_lat0", 32'(st_cyc[0]), 32'(c0 + 3));
      check("abc_lat1", 32'(st_cyc[1]), 32'(c0 + 4));
      check("abc_lat2", 32'(st_cyc[2]), 32'(c0 + 5));
      check("abc_val0", 32'(st_val[0]), 32'h41);
      check("abc_val1", 32'(st_val[1]), 32'h42);
      check("abc_val2", 32'(st_val[2]), 32'h43);
    end
    check("abc_sent", 32'(sent_cnt), 32'd3);
    check("abc_dout_held", 32'(dout), 32'h43);

    // Mode 1, GAP_LEN=3, two queued chars; mode flips mid-gap must not matter.
    do_reset();
    gap_mode = 2'd1;
    gap_len  = 3'd3;
    write_char("a");
    write_char("b");
    tick();
    c0 = cyc;
    en = 1'b1;
    tick(); tick();
    gap_mode = 2'd0;
    gap_len  = 3'd0;
    tick(); tick();
    gap_mode = 2'd1;
    gap_len  = 3'd3;
    wait_strobes(2, 60, "fixed_count");
    tick(); tick();
    if (st_val.size() >= 2) begin
      check("fixed_lat0", 32'(st_cyc[0]), 32'(c0 + 5));
      check("fixed_lat1", 32'(st_cyc[1]), 32'(c0 + 9));
      check("fixed_val0", 32'(st_val[0]), 32'h61);
      check("fixed_val1", 32'(st_val[1]), 32'h62);
    end
    if (gaps.size() >= 1) check("fixed_gap", 32'(gaps[0]), 32'd3);

    // Mode 2: 512 chars with a continuously fed FIFO; gaps follow the LFSR.
    do_reset();
    gap_mode = 2'd2;
    en       = 1'b1;
    n_wr     = 0;
    guard    = 0;
    while (st_val.size() < 512 && guard < 6000) begin
      if (n_wr < 512 && mq.size() < DEPTH - 1) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        n_wr++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      guard++;
    end
    wr_en = 1'b0;
    tick(); tick();
    check("rand_sent", 32'(st_val.size()), 32'd512);
    check("rand_gap_count", 32'(gaps.size()), 32'd511);
    bad = 0;
    foreach (gaps[i]) if (gaps[i] > 4) bad++;
    check("rand_gap_range", 32'(bad), 32'd0);
    if (gaps.size() >= 3) begin
      check("rand_gap0", 32'(gaps[0]), 32'd4);
      check("rand_gap1", 32'(gaps[1]), 32'd4);
      check("rand_gap2", 32'(gaps[2]), 32'd2);
    end

    // Overflow: 9 writes with EN=0, then exactly 8 sent in order.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h80 | 8'(8'h30 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_none_sent", 32'(st_val.size()), 32'd0);
    en = 1'b1;
    wait_strobes(8, 40, "ovf_count");
    tick(); tick(); tick();
    check("ovf_exact8", 32'(st_val.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < st_val.size()) check("ovf_order", 32'(st_val[i]), 32'(8'h30 + i));
    end
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("ovf_sent", 32'(sent_cnt), 32'd8);

    // EN dropped for 5 cycles mid-gap: counter freezes, remaining gap completes.
    do_reset();
    gap_mode = 2'd1;
    gap_len  = 3'd7;
    en       = 1'b1;
    c0       = cyc;
    write_char("x");
    tick(); tick();
    en = 1'b0;
    repeat (5) tick();
    check("freeze_no_rdy", 32'(st_val.size()), 32'd0);
    en = 1'b1;
    wait_strobes(1, 40, "freeze_count");
    if (st_cyc.size() >= 1) check("freeze_lat", 32'(st_cyc[0]), 32'(c0 + 15));

    // Reset pulse mid-GAP with 4 queued chars.
    do_reset();
    en = 1'b1;
    write_char("Z");
    wait_strobes(1, 20, "pre_rst_send");
    en       = 1'b0;
    gap_mode = 2'd1;
    gap_len  = 3'd7;
    for (int i = 0; i < 4; i++) write_char(8'(8'h50 + i));
    en = 1'b1;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midgap_rst");
    tick();
    clear_mon();
    rst_n    = 1'b1;
    gap_mode = 2'd0;
    repeat (20) tick();
    check("post_rst_no_rdy", 32'(st_val.size()), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);
    write_char("Q");
    wait_strobes(1, 20, "post_rst_send");
    if (st_val.size() >= 1) check("post_rst_val", 32'(st_val[0]), 32'h51);

    // Randomized traffic against the model.
    do_reset();
    wr_pct = 50;
    for (int cycle_i = 0; cycle_i < 3000; cycle_i++) begin
      if (cycle_i % 300 == 0) wr_pct = (cycle_i / 300) % 3 == 0 ? 20 : ((cycle_i / 300) % 3 == 1 ? 60 : 95);
      en      = ($urandom_range(0, 9) < 8);
      wr_en   = ($urandom_range(0, 99) < wr_pct);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) gap_mode = 2'($urandom);
      if ($urandom_range(0, 39) == 0) gap_len  = 3'($urandom);
      tick();
    end
    en       = 1'b1;
    wr_en    = 1'b0;
    gap_mode = 2'd0;
    repeat (60) tick();
    check("drain_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
